// File: rtl/round_controller.sv
// round_controller
//
// Per-round life-cycle sequencer for the game engine datapath. It regenerates levels,
// waits for the engine's safe zone, gates play/pause, and records win/lose outcomes.
// It also keeps the rating (difficulty) and lives counters.
//
// Optional feature macro: ROUND_CTRL_LIVES_EN
//   defined   : lives counter present. A loss that leaves zero lives ends the game.
//   undefined : no lives counter and o_lives reads 0. Every loss ends the game after RESULT.
//
// Ports:
//   clk                 clock
//   arst                asynchronous active-high reset
//   i_start             start request pulse (IDLE, GAME_OVER only)
//   i_pause_btn         pause toggle pulse (PLAY, PAUSED only)
//   i_safe_zone_rdy     engine safe-zone generation done
//   i_win / i_lose      engine round outcome levels, honoured only in PLAY
//   o_regenerate_level  one-cycle regeneration strobe (high in GEN)
//   o_pause             engine pause, low only in PLAY
//   o_rating            current rating, saturating at MAX_RATING
//   o_lives             remaining lives
//   o_state             FSM state code
//   o_last_win          outcome of the most recently finished round
//   o_game_over         high in GAME_OVER

module round_controller #(
  parameter int unsigned RATING_WIDTH  = 8,
  parameter int unsigned MAX_RATING    = 8,
  parameter int unsigned NUM_LIVES     = 3,
  parameter int unsigned RESULT_CYCLES = 3_600_000,
  parameter int unsigned RDY_TIMEOUT   = 1_000_000
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             i_start,
  input  logic                             i_pause_btn,
  input  logic                             i_safe_zone_rdy,
  input  logic                             i_win,
  input  logic                             i_lose,
  output logic                             o_regenerate_level,
  output logic                             o_pause,
  output logic [RATING_WIDTH-1:0]          o_rating,
  output logic [$clog2(NUM_LIVES+1)-1:0]   o_lives,
  output logic [2:0]                       o_state,
  output logic                             o_last_win,
  output logic                             o_game_over
);

  localparam int unsigned LivesW = $clog2(NUM_LIVES + 1);
  localparam int unsigned CntMax = (RESULT_CYCLES > RDY_TIMEOUT) ? RESULT_CYCLES : RDY_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0]         RdyLoad    = CntW'(RDY_TIMEOUT - 1);
  localparam logic [CntW-1:0]         ResultLoad = CntW'(RESULT_CYCLES - 1);
  localparam logic [RATING_WIDTH-1:0] RatingMax  = RATING_WIDTH'(MAX_RATING);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGen      = 3'd1,
    StWaitRdy  = 3'd2,
    StPlay     = 3'd3,
    StPaused   = 3'd4,
    StResult   = 3'd5,
    StGameOver = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [RATING_WIDTH-1:0] rating_q, rating_d;
  logic                    last_win_q, last_win_d;
  logic                    lose_ends_game;

`ifdef ROUND_CTRL_LIVES_EN
  logic [LivesW-1:0] lives_q, lives_d;

  // Lives were already decremented on entry to RESULT.
  assign lose_ends_game = (lives_q == '0);
`else
  // Without lives, only a lost round finishes the game.
  assign lose_ends_game = ~last_win_q;
`endif

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rating_d   = rating_q;
    last_win_d = last_win_q;
`ifdef ROUND_CTRL_LIVES_EN
    lives_d    = lives_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StGen;
        end
      end

      StGen: begin
        // Single-cycle strobe state, then arm the ready timeout.
        state_d = StWaitRdy;
        cnt_d   = RdyLoad;
      end

      StWaitRdy: begin
        // The first WAIT_RDY cycle still carries the engine's stale ready flag.
        if (i_safe_zone_rdy && (cnt_q != RdyLoad)) begin
          state_d = StPlay;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StGen;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StPlay: begin
        if (i_win) begin
          state_d    = StResult;
          cnt_d      = ResultLoad;
          last_win_d = 1'b1;
          if (rating_q < RatingMax) begin
            rating_d = rating_q + RATING_WIDTH'(1);
          end
        end else if (i_lose) begin
          state_d    = StResult;
          cnt_d      = ResultLoad;
          last_win_d = 1'b0;
`ifdef ROUND_CTRL_LIVES_EN
          if (lives_q != '0) begin
            lives_d = lives_q - LivesW'(1);
          end
`endif
        end else if (i_pause_btn) begin
          state_d = StPaused;
        end
      end

      StPaused: begin
        if (i_pause_btn) begin
          state_d = StPlay;
        end
      end

      StResult: begin
        if (cnt_q == '0) begin
          state_d = (last_win_q || !lose_ends_game) ? StGen : StGameOver;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StGameOver: begin
        if (i_start) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Entering or sitting in IDLE presents fresh game values immediately.
    if (state_d == StIdle) begin
      cnt_d      = '0;
      rating_d   = '0;
      last_win_d = 1'b0;
`ifdef ROUND_CTRL_LIVES_EN
      lives_d    = LivesW'(NUM_LIVES);
`endif
    end
  end

  // State registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rating_q   <= '0;
      last_win_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rating_q   <= rating_d;
      last_win_q <= last_win_d;
    end
  end

`ifdef ROUND_CTRL_LIVES_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lives_q <= LivesW'(NUM_LIVES);
    end else begin
      lives_q <= lives_d;
    end
  end

  assign o_lives = lives_q;
`else
  assign o_lives = '0;
`endif

  // Outputs decoded from registered state
  assign o_state            = state_q;
  assign o_regenerate_level = (state_q == StGen);
  assign o_pause            = (state_q != StPlay);
  assign o_game_over        = (state_q == StGameOver);
  assign o_rating           = rating_q;
  assign o_last_win         = last_win_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller with short RESULT/RDY timings.
// Works with or without ROUND_CTRL_LIVES_EN defined.

module tb_round_controller;

  localparam int unsigned RW = 8;

`ifdef ROUND_CTRL_LIVES_EN
  localparam logic [1:0] LIVES0      = 2'd3;
  localparam int         LOSE_ROUNDS = 3;
`else
  localparam logic [1:0] LIVES0      = 2'd0;
  localparam int         LOSE_ROUNDS = 1;
`endif

  logic          clk;
  logic          arst;
  logic          i_start;
  logic          i_pause_btn;
  logic          i_safe_zone_rdy;
  logic          i_win;
  logic          i_lose;
  logic          o_regenerate_level;
  logic          o_pause;
  logic [RW-1:0] o_rating;
  logic [1:0]    o_lives;
  logic [2:0]    o_state;
  logic          o_last_win;
  logic          o_game_over;

  int errors = 0;
  int checks = 0;

  round_controller #(
    .RATING_WIDTH (RW),
    .MAX_RATING   (8),
    .NUM_LIVES    (3),
    .RESULT_CYCLES(4),
    .RDY_TIMEOUT  (8)
  ) dut (
    .clk               (clk),
    .arst              (arst),
    .i_start           (i_start),
    .i_pause_btn       (i_pause_btn),
    .i_safe_zone_rdy   (i_safe_zone_rdy),
    .i_win             (i_win),
    .i_lose            (i_lose),
    .o_regenerate_level(o_regenerate_level),
    .o_pause           (o_pause),
    .o_rating          (o_rating),
    .o_lives           (o_lives),
    .o_state           (o_state),
    .o_last_win        (o_last_win),
    .o_game_over       (o_game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From GEN, hold ready until PLAY, bounded.
  task automatic go_play();
    bit reached = 1'b0;
    i_safe_zone_rdy = 1'b1;
    for (int i = 0; i < 12 && !reached; i++) begin
      tick();
      if (o_state === 3'd3) reached = 1'b1;
    end
    i_safe_zone_rdy = 1'b0;
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL go_play: state=%0d expected=3", o_state);
    end
  endtask

  task automatic test_reset();
    tick();
    checks += 7;
    if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got=%0d exp=0", o_state); end
    if (o_pause !== 1'b1) begin errors++; $display("FAIL reset_pause: got=%0d exp=1", o_pause); end
    if (o_regenerate_level !== 1'b0) begin
      errors++; $display("FAIL reset_regen: got=%0d exp=0", o_regenerate_level);
    end
    if (o_rating !== 8'd0) begin errors++; $display("FAIL reset_rating: got=%0d exp=0", o_rating); end
    if (o_lives !== LIVES0) begin
      errors++; $display("FAIL reset_lives: got=%0d exp=%0d", o_lives, LIVES0);
    end
    if (o_last_win !== 1'b0) begin errors++; $display("FAIL reset_last_win: got=%0d exp=0", o_last_win); end
    if (o_game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got=%0d exp=0", o_game_over); end
    arst = 1'b0;
  endtask

  task automatic test_start();
    int strobes = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_safe_zone_rdy = 1'b1;
    strobes += int'(o_regenerate_level);
    checks += 3;
    if (o_state !== 3'd1) begin errors++; $display("FAIL start_gen: got=%0d exp=1", o_state); end
    if (o_regenerate_level !== 1'b1) begin
      errors++; $display("FAIL start_strobe: got=%0d exp=1", o_regenerate_level);
    end
    if (o_pause !== 1'b1) begin errors++; $display("FAIL start_pause_gen: got=%0d exp=1", o_pause); end
    tick();
    strobes += int'(o_regenerate_level);
    checks++;
    if (o_state !== 3'd2) begin errors++; $display("FAIL start_wait1: got=%0d exp=2", o_state); end
    tick();
    strobes += int'(o_regenerate_level);
    checks++;
    if (o_state !== 3'd2) begin errors++; $display("FAIL start_wait2: got=%0d exp=2", o_state); end
    tick();
    strobes += int'(o_regenerate_level);
    i_safe_zone_rdy = 1'b0;
    checks += 3;
    if (o_state !== 3'd3) begin errors++; $display("FAIL start_play: got=%0d exp=3", o_state); end
    if (o_pause !== 1'b0) begin errors++; $display("FAIL start_pause_play: got=%0d exp=0", o_pause); end
    if (strobes != 1) begin errors++; $display("FAIL start_strobe_count: got=%0d exp=1", strobes); end
  endtask

  task automatic test_win();
    for (int r = 1; r <= 10; r++) begin
      logic [RW-1:0] exp_rating;
      exp_rating = (r < 8) ? RW'(r) : 8'd8;
      i_win = 1'b1;
      tick();
      checks += 4;
      if (o_state !== 3'd5) begin errors++; $display("FAIL win%0d_result: got=%0d exp=5", r, o_state); end
      if (o_rating !== exp_rating) begin
        errors++; $display("FAIL win%0d_rating: got=%0d exp=%0d", r, o_rating, exp_rating);
      end
      if (o_last_win !== 1'b1) begin errors++; $display("FAIL win%0d_last_win: got=%0d exp=1", r, o_last_win); end
      if (o_pause !== 1'b1) begin errors++; $display("FAIL win%0d_pause: got=%0d exp=1", r, o_pause); end
      repeat (4) tick();
      i_win = 1'b0;
      checks += 2;
      if (o_state !== 3'd1) begin errors++; $display("FAIL win%0d_gen: got=%0d exp=1", r, o_state); end
      if (o_rating !== exp_rating) begin
        errors++; $display("FAIL win%0d_once: got=%0d exp=%0d", r, o_rating, exp_rating);
      end
      go_play();
    end
  endtask

  task automatic test_lose();
    for (int k = 1; k <= LOSE_ROUNDS; k++) begin
      logic [1:0] exp_lives;
      logic [2:0] exp_next;
      exp_lives = (int'(LIVES0) >= k) ? 2'(int'(LIVES0) - k) : 2'd0;
      exp_next  = (k < LOSE_ROUNDS) ? 3'd1 : 3'd6;
      i_lose = 1'b1;
      tick();
      i_lose = 1'b0;
      checks += 3;
      if (o_state !== 3'd5) begin errors++; $display("FAIL lose%0d_result: got=%0d exp=5", k, o_state); end
      if (o_lives !== exp_lives) begin
        errors++; $display("FAIL lose%0d_lives: got=%0d exp=%0d", k, o_lives, exp_lives);
      end
      if (o_last_win !== 1'b0) begin errors++; $display("FAIL lose%0d_last_win: got=%0d exp=0", k, o_last_win); end
      repeat (4) tick();
      checks++;
      if (o_state !== exp_next) begin
        errors++; $display("FAIL lose%0d_next: got=%0d exp=%0d", k, o_state, exp_next);
      end
      if (k < LOSE_ROUNDS) go_play();
    end
    checks += 3;
    if (o_game_over !== 1'b1) begin errors++; $display("FAIL over_flag: got=%0d exp=1", o_game_over); end
    if (o_rating !== 8'd8) begin errors++; $display("FAIL over_rating: got=%0d exp=8", o_rating); end
    if (o_pause !== 1'b1) begin errors++; $display("FAIL over_pause: got=%0d exp=1", o_pause); end
    tick();
    checks++;
    if (o_state !== 3'd6) begin errors++; $display("FAIL over_hold: got=%0d exp=6", o_state); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks += 4;
    if (o_state !== 3'd0) begin errors++; $display("FAIL restart_idle: got=%0d exp=0", o_state); end
    if (o_rating !== 8'd0) begin errors++; $display("FAIL restart_rating: got=%0d exp=0", o_rating); end
    if (o_lives !== LIVES0) begin
      errors++; $display("FAIL restart_lives: got=%0d exp=%0d", o_lives, LIVES0);
    end
    if (o_game_over !== 1'b0) begin errors++; $display("FAIL restart_over: got=%0d exp=0", o_game_over); end
  endtask

  task automatic test_timeout();
    int play_seen = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_regenerate_level !== 1'b1) begin
      errors++; $display("FAIL timeout_first: got=%0d exp=1", o_regenerate_level);
    end
    for (int i = 1; i <= 18; i++) begin
      logic exp_strobe;
      exp_strobe = ((i % 9) == 0);
      tick();
      if (o_state === 3'd3) play_seen++;
      checks++;
      if (o_regenerate_level !== exp_strobe) begin
        errors++;
        $display("FAIL timeout_strobe%0d: got=%0d exp=%0d", i, o_regenerate_level, exp_strobe);
      end
    end
    checks++;
    if (play_seen != 0) begin errors++; $display("FAIL timeout_no_play: got=%0d exp=0", play_seen); end
    go_play();
  endtask

  task automatic test_pause();
    i_pause_btn = 1'b1;
    tick();
    i_pause_btn = 1'b0;
    checks += 2;
    if (o_state !== 3'd4) begin errors++; $display("FAIL pause_enter: got=%0d exp=4", o_state); end
    if (o_pause !== 1'b1) begin errors++; $display("FAIL pause_out: got=%0d exp=1", o_pause); end
    i_lose  = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (2) tick();
    checks += 2;
    if (o_state !== 3'd4) begin errors++; $display("FAIL pause_hold: got=%0d exp=4", o_state); end
    if (o_lives !== LIVES0) begin
      errors++; $display("FAIL pause_lives: got=%0d exp=%0d", o_lives, LIVES0);
    end
    i_lose      = 1'b0;
    i_pause_btn = 1'b1;
    tick();
    i_pause_btn = 1'b0;
    checks += 3;
    if (o_state !== 3'd3) begin errors++; $display("FAIL pause_resume: got=%0d exp=3", o_state); end
    if (o_pause !== 1'b0) begin errors++; $display("FAIL pause_resume_out: got=%0d exp=0", o_pause); end
    if (o_lives !== LIVES0) begin
      errors++; $display("FAIL pause_resume_lives: got=%0d exp=%0d", o_lives, LIVES0);
    end
  endtask

  task automatic test_win_lose_same();
    i_win  = 1'b1;
    i_lose = 1'b1;
    tick();
    i_win  = 1'b0;
    i_lose = 1'b0;
    checks += 4;
    if (o_state !== 3'd5) begin errors++; $display("FAIL both_result: got=%0d exp=5", o_state); end
    if (o_last_win !== 1'b1) begin errors++; $display("FAIL both_last_win: got=%0d exp=1", o_last_win); end
    if (o_rating !== 8'd1) begin errors++; $display("FAIL both_rating: got=%0d exp=1", o_rating); end
    if (o_lives !== LIVES0) begin
      errors++; $display("FAIL both_lives: got=%0d exp=%0d", o_lives, LIVES0);
    end
    repeat (4) tick();
    checks++;
    if (o_state !== 3'd1) begin errors++; $display("FAIL both_gen: got=%0d exp=1", o_state); end
    go_play();
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    i_win = 1'b1;
    tick();
    i_win = 1'b0;
    checks += 2;
    if (o_state !== 3'd5) begin errors++; $display("FAIL mid_result: got=%0d exp=5", o_state); end
    if (o_rating !== 8'd2) begin errors++; $display("FAIL mid_rating: got=%0d exp=2", o_rating); end
    tick();
    #2;
    arst = 1'b1;
    #1;
    checks += 6;
    if (o_state !== 3'd0) begin errors++; $display("FAIL mid_state: got=%0d exp=0", o_state); end
    if (o_rating !== 8'd0) begin errors++; $display("FAIL mid_rating0: got=%0d exp=0", o_rating); end
    if (o_lives !== LIVES0) begin
      errors++; $display("FAIL mid_lives: got=%0d exp=%0d", o_lives, LIVES0);
    end
    if (o_last_win !== 1'b0) begin errors++; $display("FAIL mid_last_win: got=%0d exp=0", o_last_win); end
    if (o_pause !== 1'b1) begin errors++; $display("FAIL mid_pause: got=%0d exp=1", o_pause); end
    if (o_regenerate_level !== 1'b0) begin
      errors++; $display("FAIL mid_regen: got=%0d exp=0", o_regenerate_level);
    end
    tick();
    arst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      strobes += int'(o_regenerate_level);
    end
    checks += 2;
    if (strobes != 0) begin errors++; $display("FAIL mid_no_strobe: got=%0d exp=0", strobes); end
    if (o_state !== 3'd0) begin errors++; $display("FAIL mid_idle: got=%0d exp=0", o_state); end
  endtask

  initial begin
    arst            = 1'b1;
    i_start         = 1'b0;
    i_pause_btn     = 1'b0;
    i_safe_zone_rdy = 1'b0;
    i_win           = 1'b0;
    i_lose          = 1'b0;
    test_reset();
    test_start();
    test_win();
    test_lose();
    test_timeout();
    test_pause();
    test_win_lose_same();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
